code_stabilizer_display: RTL and testbench

Downstream consumer of the 7-input priority/one-hot encoder's 3-bit code {F3,F2,F1}. The encoder reports code 0 for "no input active" and 1..7 for the active input index.
- Synchronizes the raw combinational code into the clock domain.
- Accepts a code only after it has been stable for a programmable number of cycles.
- Presents the accepted code with a valid/ack handshake, drives a 7-segment digit and counts accepted events.

---
 rtl/code_stabilizer_display_pkg.sv | 27 ++
 rtl/code_stabilizer_display_seg7_decoder_3b.sv | 29 ++
 rtl/code_stabilizer_display.sv | 138 +++++++++++++
 tb/tb_code_stabilizer_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/code_stabilizer_display_pkg.sv
// Shared types and constants for the code stabilizer / display block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state enum, the code width and the 7-segment patterns
// ({g,f,e,d,c,b,a}, active-high) used by the decoder.
package code_stabilizer_display_pkg;

   localparam int CODE_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      HOLD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;

endpackage

// File: rtl/code_stabilizer_display_seg7_decoder_3b.sv
// 3-bit code to 7-segment pattern lookup; code 0 shows a blank digit.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of the input).
//
// Ports:
//   i_code  3-bit code, 0 = idle, 1..7 = digit to show
//   o_seg   active-high segments {g,f,e,d,c,b,a}
module seg7_decoder_3b
   import code_stabilizer_display_pkg::*;
(
   input  logic [CODE_W-1:0] i_code,
   output logic [6:0]        o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         3'd1:    o_seg = SEG_1;
         3'd2:    o_seg = SEG_2;
         3'd3:    o_seg = SEG_3;
         3'd4:    o_seg = SEG_4;
         3'd5:    o_seg = SEG_5;
         3'd6:    o_seg = SEG_6;
         3'd7:    o_seg = SEG_7;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/code_stabilizer_display.sv
// Debounces the encoder code, presents accepted codes with valid/ack, a 7-seg digit and a saturating event count.
// Latency: a code steady before edge 1 raises code_valid after edge 2+STABLE_CYCLES.
// Backpressure: code_valid holds the code until ack; a new code is accepted only after an idle gap.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   code_in     raw encoder code {F3,F2,F1}, 0 = idle
//   ack         consumer acknowledge, only looked at while holding a code
//   code_out    last accepted code
//   code_valid  high from acceptance until ack is sampled
//   seg         registered 7-segment pattern of code_out
//   evt_count   saturating count of accepted codes
//   glitch      one-cycle pulse when a candidate is dropped before acceptance
module code_stabilizer_display
   import code_stabilizer_display_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] code_in,
   input  logic              ack,
   output logic [CODE_W-1:0] code_out,
   output logic              code_valid,
   output logic [6:0]        seg,
   output logic [CNT_W-1:0]  evt_count,
   output logic              glitch
);

   localparam int SC_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0] LAST_CNT = SC_W'(STABLE_CYCLES - 1);

   logic [CODE_W-1:0] r_sync1, r_sync2;
   state_t            r_state, w_state_nxt;
   logic [CODE_W-1:0] r_cand, w_cand_nxt;
   logic [SC_W-1:0]   r_stab_cnt, w_stab_cnt_nxt;
   logic [CODE_W-1:0] r_code_out;
   logic              r_valid;
   logic [6:0]        r_seg;
   logic [CNT_W-1:0]  r_evt;
   logic              w_accept, w_ack_taken, w_glitch;
   logic [6:0]        w_seg_dec;

   // Decode the candidate so the pattern is ready on the accepting edge.
   seg7_decoder_3b u_seg7 (
      .i_code (r_cand),
      .o_seg  (w_seg_dec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_state    <= IDLE;
         r_cand     <= '0;
         r_stab_cnt <= '0;
         r_code_out <= '0;
         r_valid    <= 1'b0;
         r_seg      <= SEG_BLANK;
         r_evt      <= '0;
      end else begin
         r_sync1    <= code_in;
         r_sync2    <= r_sync1;
         r_state    <= w_state_nxt;
         r_cand     <= w_cand_nxt;
         r_stab_cnt <= w_stab_cnt_nxt;
         if (w_accept) begin
            r_code_out <= r_cand;
            r_seg      <= w_seg_dec;
            r_valid    <= 1'b1;
            if (r_evt != {CNT_W{1'b1}})
               r_evt <= r_evt + 1'b1;
         end else if (w_ack_taken) begin
            r_valid <= 1'b0;
         end
      end
   end

   // The glitch output is decoded from registered state and the
   // synchronized code only, so it is clean and lasts one cycle per abort.
   always_comb begin
      w_state_nxt    = r_state;
      w_cand_nxt     = r_cand;
      w_stab_cnt_nxt = r_stab_cnt;
      w_accept       = 1'b0;
      w_ack_taken    = 1'b0;
      w_glitch       = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_sync2 != '0) begin
               w_state_nxt    = CHECK;
               w_cand_nxt     = r_sync2;
               w_stab_cnt_nxt = SC_W'(1);
            end
         end
         CHECK: begin
            if (r_sync2 == '0) begin
               w_state_nxt    = IDLE;
               w_stab_cnt_nxt = '0;
               w_glitch       = 1'b1;
            end else if (r_sync2 == r_cand) begin
               if (r_stab_cnt == LAST_CNT) begin
                  w_state_nxt    = HOLD;
                  w_stab_cnt_nxt = '0;
                  w_accept       = 1'b1;
               end else begin
                  w_stab_cnt_nxt = r_stab_cnt + 1'b1;
               end
            end else begin
               w_cand_nxt     = r_sync2;
               w_stab_cnt_nxt = SC_W'(1);
               w_glitch       = 1'b1;
            end
         end
         HOLD: begin
            // Entry into HOLD happens on an edge, so ack can act no
            // earlier than the next edge: valid is high at least a cycle.
            if (ack) begin
               w_state_nxt = RELEASE;
               w_ack_taken = 1'b1;
            end
         end
         RELEASE: begin
            if (r_sync2 == '0)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign code_out   = r_code_out;
   assign code_valid = r_valid;
   assign seg        = r_seg;
   assign evt_count  = r_evt;
   assign glitch     = w_glitch;

endmodule

// File: tb/tb_code_stabilizer_display.sv
// Self-checking bench: directed scenarios then random code/ack traffic against a run-length reference model.
// Latency: model tracks the two-stage input delay and the stability window.
// Backpressure: ack driven directly and randomly.
module tb_code_stabilizer_display;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] code_in = 3'd0;
   logic       ack = 1'b0;

   logic [2:0] code_out8, code_out2;
   logic       valid8, valid2, glitch8, glitch2;
   logic [6:0] seg8, seg2;
   logic [7:0] evt8;
   logic [1:0] evt2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_p1, m_p2;        // code_in delayed by one and two edges
   int m_cur, m_run;      // current candidate value and consecutive-edge run length
   int m_hold;            // code presented, waiting for ack
   int m_need_idle;       // accepted code seen, waiting for a zero
   int m_out, m_cnt8, m_cnt2;

   logic [6:0] seg_tab [8];

   always #5 clk = ~clk;

   code_stabilizer_display #(.STABLE_CYCLES(SC), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .code_in(code_in), .ack(ack),
      .code_out(code_out8), .code_valid(valid8), .seg(seg8),
      .evt_count(evt8), .glitch(glitch8)
   );

   code_stabilizer_display #(.STABLE_CYCLES(SC), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .code_in(code_in), .ack(ack),
      .code_out(code_out2), .code_valid(valid2), .seg(seg2),
      .evt_count(evt2), .glitch(glitch2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_p1 = 0; m_p2 = 0; m_cur = 0; m_run = 0;
      m_hold = 0; m_need_idle = 0; m_out = 0; m_cnt8 = 0; m_cnt2 = 0;
   endtask

   // One clock edge of the reference behaviour, using pre-edge inputs.
   task automatic model_edge(input int cin, input int a);
      int s;
      s = m_p2;
      if (m_hold != 0) begin
         if (a != 0) m_hold = 0;
      end else if (m_need_idle != 0) begin
         if (s == 0) m_need_idle = 0;
      end else if (s == 0) begin
         m_run = 0;
      end else if (m_run > 0 && s == m_cur) begin
         if (m_run + 1 == SC) begin
            m_out = m_cur;
            m_hold = 1;
            m_need_idle = 1;
            m_run = 0;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
         end else begin
            m_run++;
         end
      end else begin
         m_cur = s;
         m_run = 1;
      end
      m_p2 = m_p1;
      m_p1 = cin;
   endtask

   function automatic int exp_glitch();
      return (m_need_idle == 0 && m_run > 0 && m_p2 != m_cur) ? 1 : 0;
   endfunction

   task automatic compare_all();
      chk("code_valid", {31'd0, valid8}, m_hold);
      chk("code_out",   {29'd0, code_out8}, m_out);
      chk("seg",        {25'd0, seg8}, {25'd0, seg_tab[m_out]});
      chk("evt8",       {24'd0, evt8}, m_cnt8);
      chk("glitch",     {31'd0, glitch8}, exp_glitch());
      chk("evt2",       {30'd0, evt2}, m_cnt2);
      chk("valid2",     {31'd0, valid2}, m_hold);
      chk("glitch2",    {31'd0, glitch2}, exp_glitch());
   endtask

   task automatic run(input int c, input int a, input int n);
      for (int i = 0; i < n; i++) begin
         code_in = 3'(c);
         ack = a[0];
         @(posedge clk);
         model_edge(c, a);
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_code_out"}, {29'd0, code_out8}, 0);
      chk({tag, "_valid"},    {31'd0, valid8}, 0);
      chk({tag, "_seg"},      {25'd0, seg8}, 0);
      chk({tag, "_evt8"},     {24'd0, evt8}, 0);
      chk({tag, "_evt2"},     {30'd0, evt2}, 0);
      chk({tag, "_glitch"},   {31'd0, glitch8}, 0);
   endtask

   initial begin
      seg_tab[0] = 7'b0000000; seg_tab[1] = 7'b0000110;
      seg_tab[2] = 7'b1011011; seg_tab[3] = 7'b1001111;
      seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
      seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111;
      model_reset();

      // Reset takes effect before any clock edge.
      code_in = 3'($urandom_range(7));
      ack = 1'($urandom_range(1));
      #1 rst = 1'b1;
      #1 check_reset_values("rst0");
      @(negedge clk);
      rst = 1'b0;
      code_in = 3'd0;
      ack = 1'b0;

      // Steady 5: acceptance, then ack clears valid.
      run(5, 0, 10);
      run(5, 1, 1);
      run(0, 0, 4);

      // Short 3 then idle: one abort pulse, no acceptance.
      run(3, 0, 2);
      run(0, 0, 6);

      // Short 3 then 6: one abort, then 6 accepted.
      run(3, 0, 2);
      run(6, 0, 10);
      run(6, 1, 1);
      run(0, 0, 4);

      // Repeated 5 with idle gaps; held 5 after ack is not re-accepted.
      run(5, 0, 8);
      run(5, 1, 1);
      run(5, 0, 5);
      run(0, 0, 4);
      for (int k = 0; k < 3; k++) begin
         run(5, 0, 8);
         run(5, 1, 2);
         run(0, 0, 4);
      end

      // Asynchronous reset in the middle of HOLD, between edges.
      run(2, 0, 8);
      #2 rst = 1'b1;
      #1 check_reset_values("rst_hold");
      model_reset();
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      run(2, 0, 8);
      run(2, 1, 1);
      run(0, 0, 3);

      // Random traffic.
      for (int k = 0; k < 150; k++) begin
         int c, len, a;
         c = ($urandom_range(2) == 0) ? 0 : $urandom_range(1, 7);
         len = $urandom_range(1, 8);
         for (int j = 0; j < len; j++) begin
            a = ($urandom_range(3) == 0) ? 1 : 0;
            run(c, a, 1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
